decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
- Parametrised successor to the single-cycle RV32I control unit.
- Buffers fetched instructions in a DEPTH-entry queue and decodes the head entry into a packed control bundle.
- Issues to the execute stage over a valid/ready handshake.
- Serialises SYSTEM-opcode instructions, blocks issue after a trap or xRET until redirect, and counts issued instructions.
- Sits between fetch and execute.

Parameters:
XLEN, 32, instruction/PC/counter width
DEPTH, 4, queue entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
if_valid  in  1  fetch offers instruction
if_ready  out  1  queue can accept
if_instr  in  32  instruction word
if_pc  in  XLEN  instruction PC
mode  in  2  current privilege (USER/SUPERV/MACHINE per cpu/defines.h)
drained  in  1  execute and later stages empty
flush  in  1  discard queue, return to RUN
id_valid  out  1  control bundle valid
id_ready  in  1  execute accepts bundle
id_pc  out  XLEN  PC of head instruction
id_instr  out  32  head instruction word
id_alu_op  out  5  ALU op code (cpu/defines.h encodings)
id_wr_reg  out  1  rd write enable
id_mem_wr  out  1  store
id_mem_rd  out  1  load
id_mem_size  out  2  0 none, 1 byte, 2 half, 3 word
id_load_uns  out  1  zero-extend load
id_branch  out  1  conditional branch
id_jump  out  1  jal/jalr
id_csr  out  1  CSR access
id_excep  out  1  raise exception
id_excep_code  out  4  mcause code
id_ret  out  1  xRET
issue_count  out  XLEN  instructions issued since reset

Behaviour:
- Reset (rst_n=0, async):
  - Pointers and count = 0; state = RUN; issue_count = 0.
  - if_ready = 1; id_valid = 0; all id_* decode outputs = 0.
- Queue: circular buffer of {instr, pc}; count width clog2(DEPTH+1).
  - if_ready = (count < DEPTH); no full-queue bypass.
  - Push when if_valid&&if_ready; pop when id_valid&&id_ready.
  - Push and pop in the same cycle leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- Latency: an instruction pushed at edge N can be presented at the earliest in the cycle after edge N; never combinationally from if_*.
- Decode is combinational from the head entry. Outputs are forced to 0 whenever count==0 or state!=RUN.
- Decode rules:
  - Legal opcodes: 0110011, 0010011, 0000011, 1100111, 0100011, 1100011, 0110111, 0010111, 1101111, 1110011.
  - Any other opcode: id_excep=1, code 2.
  - ecall: code 8/9/11 for USER/SUPERV/MACHINE.
  - mret with mode<MACHINE, or sret with mode<SUPERV: code 2. Otherwise the xRET sets id_ret.
  - CSR ops (funct3!=0) set id_csr and id_wr_reg.
- id_valid = (count>0) && state==RUN && (!head_is_system || drained).
  - head_is_system: opcode 1110011.
  - Holding id_valid low while waiting for drained is not a handshake violation.
- id_valid/id_* stability: once id_valid=1, id_valid and all id_* hold stable until accepted, flush, or reset. mode changes while presented must not alter an offered bundle. Capture mode into the head's decode when first presented.
- FSM:
  - RUN -> TRAP_WAIT on a pop whose bundle has id_excep or id_ret.
  - TRAP_WAIT: id_valid=0; the queue may keep filling.
  - TRAP_WAIT -> RUN only on flush.
- flush:
  - Synchronous: next cycle count=0 and state=RUN.
  - Flush wins over a simultaneous push and pop. The popped instruction still counts as issued if the handshake completed that cycle.
- issue_count increments by 1 on each pop and wraps modulo 2^XLEN.

Optional Feature:
- Macro RV32M_DECODE_EN.
- Defined: opcode 0110011 with funct7=0000001 decodes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU to their ALU ops.
- Undefined: those encodings set id_excep=1, code 2, and enter TRAP_WAIT on issue.

Test Plan:
- Push 6 instructions (addi x1,x0,1 = 0x00100093, ...) with id_ready=0, DEPTH=4:
  - if_ready drops after the 4th push.
  - id_alu_op = ADD, id_wr_reg=1.
  - id_pc = first PC; bundle stable.
- Simultaneous push/pop at count=2 over 10 cycles -> count stays 2; PCs emerge in order; issue_count=10; pointer wrap exercised.
- CSR instr 0x30002573 at head with drained=0 for 5 cycles -> id_valid=0; drained=1 -> id_valid=1, id_csr=1.
- ecall 0x00000073 in USER mode, accepted -> id_excep=1, code 8. Next instruction is held (id_valid=0) until flush; after flush, count=0.
- mret 0x30200073 in SUPERV -> id_excep=1, code 2. In MACHINE -> id_ret=1, id_excep=0.
- MUL 0x02208033 -> with RV32M_DECODE_EN: id_alu_op=MUL. Without it: id_excep=1, code 2. Assert rst_n=0 mid-stream -> if_ready=1, id_valid=0, issue_count=0 immediately.

Source files
------------

// File: rtl/decode_queue.sv
// Instruction queue + RV32I decode between fetch and execute; serialises SYSTEM ops and stalls after traps.
// Optional RV32M_DECODE_EN: decode the M-extension (funct7=0000001) instead of trapping on it.
module decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic [1:0]      mode,
  input  logic            drained,
  input  logic            flush,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic [4:0]      id_alu_op,
  output logic            id_wr_reg,
  output logic            id_mem_wr,
  output logic            id_mem_rd,
  output logic [1:0]      id_mem_size,
  output logic            id_load_uns,
  output logic            id_branch,
  output logic            id_jump,
  output logic            id_csr,
  output logic            id_excep,
  output logic [3:0]      id_excep_code,
  output logic            id_ret,
  output logic [XLEN-1:0] issue_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] MODE_U = 2'd0;
  localparam logic [1:0] MODE_S = 2'd1;
  localparam logic [1:0] MODE_M = 2'd3;

  // ALU op encodings shared with the execute stage; branches use BR|funct3.
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
`ifdef RV32M_DECODE_EN
  localparam logic [4:0] ALU_MUL  = 5'd10;
`endif
  localparam logic [4:0] ALU_LUI  = 5'd18;
  localparam logic [4:0] ALU_BR   = 5'd24;

  typedef enum logic {RUN, TRAP_WAIT} state_t;

  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  state_t          state_q, state_d;
  logic [XLEN-1:0] issue_count_q, issue_count_d;
  logic            hold_q, hold_d;
  logic [1:0]      mode_q, mode_d;

  logic            push, pop, gate, head_sys;
  logic [31:0]     hi;
  logic [XLEN-1:0] hpc;
  logic [1:0]      eff_mode;
  logic [6:0]      opc, f7;
  logic [2:0]      f3;

  logic [4:0] d_alu;
  logic       d_wr, d_mw, d_mr, d_uns, d_br, d_jmp, d_csr, d_exc, d_ret;
  logic [1:0] d_sz;
  logic [3:0] d_code;

  function automatic logic [4:0] alu_of(input logic [2:0] fn, input logic alt);
    case (fn)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  assign hi  = instr_mem[rd_ptr_q];
  assign hpc = pc_mem[rd_ptr_q];
  assign opc = hi[6:0];
  assign f3  = hi[14:12];
  assign f7  = hi[31:25];
  // Once a bundle is on offer, decode against the mode it was first shown with.
  assign eff_mode = hold_q ? mode_q : mode;

  always_comb begin
    d_alu  = ALU_ADD;
    d_wr   = 1'b0;
    d_mw   = 1'b0;
    d_mr   = 1'b0;
    d_sz   = 2'd0;
    d_uns  = 1'b0;
    d_br   = 1'b0;
    d_jmp  = 1'b0;
    d_csr  = 1'b0;
    d_exc  = 1'b0;
    d_code = 4'd0;
    d_ret  = 1'b0;
    case (opc)
      7'b0110011: begin
        if (f7 == 7'b0000001) begin
`ifdef RV32M_DECODE_EN
          d_wr  = 1'b1;
          d_alu = ALU_MUL + {2'b00, f3};
`else
          d_exc  = 1'b1;
          d_code = 4'd2;
`endif
        end else begin
          d_wr  = 1'b1;
          d_alu = alu_of(f3, f7[5]);
        end
      end
      7'b0010011: begin
        d_wr  = 1'b1;
        d_alu = alu_of(f3, (f3 == 3'd5) && f7[5]);
      end
      7'b0000011: begin
        d_wr  = 1'b1;
        d_mr  = 1'b1;
        d_sz  = f3[1:0] + 2'd1;
        d_uns = f3[2];
      end
      7'b0100011: begin
        d_mw = 1'b1;
        d_sz = f3[1:0] + 2'd1;
      end
      7'b1100011: begin
        d_br  = 1'b1;
        d_alu = ALU_BR | {2'b00, f3};
      end
      7'b0110111: begin
        d_wr  = 1'b1;
        d_alu = ALU_LUI;
      end
      7'b0010111: d_wr = 1'b1;
      7'b1101111, 7'b1100111: begin
        d_wr  = 1'b1;
        d_jmp = 1'b1;
      end
      7'b1110011: begin
        if (f3 != 3'd0) begin
          d_csr = 1'b1;
          d_wr  = 1'b1;
        end else begin
          case (hi[31:20])
            12'h000: begin
              d_exc = 1'b1;
              case (eff_mode)
                MODE_U:  d_code = 4'd8;
                MODE_S:  d_code = 4'd9;
                default: d_code = 4'd11;
              endcase
            end
            12'h001: begin
              d_exc  = 1'b1;
              d_code = 4'd3;
            end
            12'h302: begin
              if (eff_mode < MODE_M) begin
                d_exc  = 1'b1;
                d_code = 4'd2;
              end else d_ret = 1'b1;
            end
            12'h102: begin
              if (eff_mode < MODE_S) begin
                d_exc  = 1'b1;
                d_code = 4'd2;
              end else d_ret = 1'b1;
            end
            12'h105: ;
            default: begin
              d_exc  = 1'b1;
              d_code = 4'd2;
            end
          endcase
        end
      end
      default: begin
        d_exc  = 1'b1;
        d_code = 4'd2;
      end
    endcase
  end

  assign gate     = (count_q != '0) && (state_q == RUN);
  assign head_sys = (opc == 7'b1110011);
  assign id_valid = gate && (!head_sys || drained || hold_q);
  assign if_ready = (count_q < CW'(DEPTH));
  assign push     = if_valid && if_ready;
  assign pop      = id_valid && id_ready;

  always_comb begin
    id_pc         = gate ? hpc : '0;
    id_instr      = gate ? hi : '0;
    id_alu_op     = gate ? d_alu : '0;
    id_wr_reg     = gate && d_wr;
    id_mem_wr     = gate && d_mw;
    id_mem_rd     = gate && d_mr;
    id_mem_size   = gate ? d_sz : '0;
    id_load_uns   = gate && d_uns;
    id_branch     = gate && d_br;
    id_jump       = gate && d_jmp;
    id_csr        = gate && d_csr;
    id_excep      = gate && d_exc;
    id_excep_code = gate ? d_code : '0;
    id_ret        = gate && d_ret;
  end

  assign issue_count = issue_count_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    wr_ptr_d      = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d      = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    issue_count_d = issue_count_q + {{(XLEN-1){1'b0}}, pop};
    state_d       = state_q;
    if (state_q == RUN && pop && (id_excep || id_ret)) state_d = TRAP_WAIT;
    hold_d = id_valid && !id_ready;
    mode_d = (id_valid && !hold_q) ? mode : mode_q;
    // Flush drops queued work but an issue completing this cycle still counts.
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      state_d  = RUN;
      hold_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= if_instr;
      pc_mem[wr_ptr_q]    <= if_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      state_q       <= RUN;
      issue_count_q <= '0;
      hold_q        <= 1'b0;
      mode_q        <= '0;
    end else begin
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      state_q       <= state_d;
      issue_count_q <= issue_count_d;
      hold_q        <= hold_d;
      mode_q        <= mode_d;
    end
  end
endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: stimulus queues expected bundles, a negedge monitor checks issues.
module tb_decode_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic if_valid, if_ready, drained, flush, id_valid, id_ready;
  logic [31:0] if_instr, id_instr;
  logic [XLEN-1:0] if_pc, id_pc, issue_count;
  logic [1:0] mode, id_mem_size;
  logic [4:0] id_alu_op;
  logic id_wr_reg, id_mem_wr, id_mem_rd, id_load_uns, id_branch, id_jump, id_csr, id_excep, id_ret;
  logic [3:0] id_excep_code;

  always #5 clk = ~clk;

  decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .mode(mode), .drained(drained), .flush(flush), .id_valid(id_valid),
    .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr), .id_alu_op(id_alu_op),
    .id_wr_reg(id_wr_reg), .id_mem_wr(id_mem_wr), .id_mem_rd(id_mem_rd),
    .id_mem_size(id_mem_size), .id_load_uns(id_load_uns), .id_branch(id_branch),
    .id_jump(id_jump), .id_csr(id_csr), .id_excep(id_excep), .id_excep_code(id_excep_code),
    .id_ret(id_ret), .issue_count(issue_count)
  );

  typedef struct packed {
    logic [4:0] alu;
    logic wr, mw, mr;
    logic [1:0] sz;
    logic uns, br, jmp, csr, exc;
    logic [3:0] code;
    logic ret;
  } dec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    dec_t d;
  } ent_t;

  ent_t sb[$];
  ent_t mon_e;
  int total = 0;
  int bad = 0;
  logic prev_hold = 1'b0;
  logic [83:0] prev_b, cur_b;

  assign cur_b = {id_pc, id_instr, id_alu_op, id_wr_reg, id_mem_wr, id_mem_rd, id_mem_size,
                  id_load_uns, id_branch, id_jump, id_csr, id_excep, id_excep_code, id_ret};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic dec_t mk(input logic [4:0] alu, input logic wr, input logic mw, input logic mr,
                              input logic [1:0] sz, input logic uns, input logic br, input logic jmp,
                              input logic csr, input logic exc, input logic [3:0] code, input logic ret);
    return {alu, wr, mw, mr, sz, uns, br, jmp, csr, exc, code, ret};
  endfunction

  function automatic dec_t dalu(input logic [4:0] alu);
    return mk(alu, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endfunction

  function automatic dec_t dexc(input logic [3:0] code);
    return mk(5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, code, 1'b0);
  endfunction

  // Monitor: stability of an offered bundle, then in-order comparison on each issue.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("stable_valid", id_valid, 1);
        chk("stable_bundle", cur_b, prev_b);
      end
      if (id_valid && id_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_issue: got pc %0h want none", id_pc);
        end else begin
          mon_e = sb.pop_front();
          chk("issue_bundle", cur_b, mon_e);
        end
      end
      prev_hold = id_valid && !id_ready && !flush;
      prev_b = cur_b;
      if (flush) sb.delete();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input dec_t d);
    int n;
    logic rdy;
    n = 0;
    if_valid = 1'b1;
    if_instr = ins;
    if_pc = pc;
    do begin
      @(negedge clk);
      rdy = if_ready;
      tick();
      n++;
    end while (!rdy && n < 50);
    if (!rdy) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got if_ready 0 want 1 pc %0h", pc);
    end else sb.push_back({pc, ins, d});
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  logic [31:0] t2_ins [12];
  dec_t t2_dec [12];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    t2_ins[0]  = 32'h002081B3; t2_dec[0]  = dalu(5'd0);
    t2_ins[1]  = 32'h402081B3; t2_dec[1]  = dalu(5'd1);
    t2_ins[2]  = 32'h0000A283; t2_dec[2]  = mk(5'd0, 1, 0, 1, 2'd3, 0, 0, 0, 0, 0, 4'd0, 0);
    t2_ins[3]  = 32'h0050A223; t2_dec[3]  = mk(5'd0, 0, 1, 0, 2'd3, 0, 0, 0, 0, 0, 4'd0, 0);
    t2_ins[4]  = 32'h00208463; t2_dec[4]  = mk(5'd24, 0, 0, 0, 2'd0, 0, 1, 0, 0, 0, 4'd0, 0);
    t2_ins[5]  = 32'h12345337; t2_dec[5]  = dalu(5'd18);
    t2_ins[6]  = 32'h010000EF; t2_dec[6]  = mk(5'd0, 1, 0, 0, 2'd0, 0, 0, 1, 0, 0, 4'd0, 0);
    t2_ins[7]  = 32'h00F0F393; t2_dec[7]  = dalu(5'd9);
    t2_ins[8]  = 32'h0000C403; t2_dec[8]  = mk(5'd0, 1, 0, 1, 2'd1, 1, 0, 0, 0, 0, 4'd0, 0);
    t2_ins[9]  = 32'h0020C1B3; t2_dec[9]  = dalu(5'd5);
    t2_ins[10] = 32'h4030D293; t2_dec[10] = dalu(5'd7);
    t2_ins[11] = 32'h0020A1B3; t2_dec[11] = dalu(5'd3);

    if_valid = 0; if_instr = 0; if_pc = 0; mode = 2'd3; drained = 1; flush = 0; id_ready = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_if_ready", if_ready, 1);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_issue_count", issue_count, 0);
    chk("rst_bundle", cur_b, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Fill to DEPTH with execute stalled.
    for (int i = 0; i < 4; i++) send(32'h00100093 + (i << 20), 32'h100 + 4 * i, dalu(5'd0));
    chk("full_if_ready", if_ready, 0);
    chk("full_id_valid", id_valid, 1);
    chk("full_id_pc", id_pc, 32'h100);
    chk("full_alu_op", id_alu_op, 0);
    chk("full_wr_reg", id_wr_reg, 1);
    repeat (3) tick();
    chk("held_id_pc", id_pc, 32'h100);
    id_ready = 1;
    send(32'h00500293, 32'h110, dalu(5'd0));
    send(32'h00600313, 32'h114, dalu(5'd0));
    if_valid = 0;
    wait_empty();
    chk("t1_issue_count", issue_count, 6);

    // Steady push+pop at occupancy 2, wrapping pointers.
    id_ready = 0;
    send(t2_ins[0], 32'h200, t2_dec[0]);
    send(t2_ins[1], 32'h204, t2_dec[1]);
    id_ready = 1;
    for (int i = 2; i < 12; i++) begin
      send(t2_ins[i], 32'h200 + 4 * i, t2_dec[i]);
      chk("pp_if_ready", if_ready, 1);
      chk("pp_id_valid", id_valid, 1);
    end
    if_valid = 0;
    chk("pp_issue_count", issue_count, 16);
    wait_empty();
    chk("t2_issue_count", issue_count, 18);

    // CSR access waits for drained.
    drained = 0;
    send(32'h30002573, 32'h300, mk(5'd0, 1, 0, 0, 2'd0, 0, 0, 0, 1, 0, 4'd0, 0));
    if_valid = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("csr_wait_valid", id_valid, 0);
    end
    drained = 1;
    #1;
    chk("csr_go_valid", id_valid, 1);
    chk("csr_go_csr", id_csr, 1);
    wait_empty();

    // ecall from USER traps; following instruction is blocked until flush.
    mode = 2'd0;
    send(32'h00000073, 32'h400, dexc(4'd8));
    send(32'h00100093, 32'h404, dalu(5'd0));
    if_valid = 0;
    repeat (4) tick();
    chk("trap_hold_valid", id_valid, 0);
    chk("trap_if_ready", if_ready, 1);
    do_flush();
    chk("flush_valid", id_valid, 0);
    chk("flush_pc", id_pc, 0);
    send(32'h00200113, 32'h500, dalu(5'd0));
    if_valid = 0;
    wait_empty();

    // mret privilege check, and mode captured while the bundle is on offer.
    mode = 2'd1;
    send(32'h30200073, 32'h600, dexc(4'd2));
    if_valid = 0;
    wait_empty();
    do_flush();
    mode = 2'd3;
    id_ready = 0;
    send(32'h30200073, 32'h700, mk(5'd0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 4'd0, 1));
    if_valid = 0;
    tick();
    mode = 2'd0;
    tick();
    tick();
    chk("mret_mode_hold_ret", id_ret, 1);
    chk("mret_mode_hold_exc", id_excep, 0);
    id_ready = 1;
    wait_empty();
    do_flush();
    mode = 2'd3;

    // MUL: legal only with the M decode enabled.
`ifdef RV32M_DECODE_EN
    send(32'h02208033, 32'h800, dalu(5'd10));
`else
    send(32'h02208033, 32'h800, dexc(4'd2));
`endif
    if_valid = 0;
    wait_empty();
    do_flush();
    chk("pre_rst_issue_count", issue_count, 24);

    // Asynchronous reset mid-stream.
    id_ready = 0;
    send(32'h00100093, 32'h900, dalu(5'd0));
    send(32'h00200113, 32'h904, dalu(5'd0));
    if_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_if_ready", if_ready, 1);
    chk("arst_id_valid", id_valid, 0);
    chk("arst_issue_count", issue_count, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", id_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
